id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register feeding the ALU. Decodes opcode/funct3/funct7[5] into the 4-bit alu_ctrl.
//  Selects and registers operands A/B and carries EX/MEM/WB control bits downstream.
//  Supports stall (hold) and flush (inject bubble); ALU operands are valid one cycle after capture.
// PARAMETERS
//  XLEN      32   datapath width of pc, register data, immediate, operands
//  REG_AW    5    register address width
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  stall        in   1       hold all outputs (hazard unit)
//  flush        in   1       replace next contents with bubble (branch/jump taken)
//  in_valid     in   1       ID slot holds a real instruction
//  in_pc        in   XLEN    instruction address
//  in_rs1_data  in   XLEN    register-file read 1
//  in_rs2_data  in   XLEN    register-file read 2
//  in_imm       in   XLEN    sign-extended immediate from decoder
//  in_opcode    in   7       instr[6:0]
//  in_funct3    in   3       instr[14:12]
//  in_funct7_5  in   1       instr[30]
//  in_rs1_addr, in_rs2_addr, in_rd   in  REG_AW  register indices
//  ex_valid     out  1       EX slot holds a real instruction
//  ex_op_a      out  XLEN    ALU rs1 operand
//  ex_op_b      out  XLEN    ALU rs2 operand
//  ex_alu_ctrl  out  4       ALU operation code
//  ex_rs2_data  out  XLEN    store data (unselected rs2)
//  ex_pc        out  XLEN    registered pc
//  ex_rd, ex_rs1_addr, ex_rs2_addr  out  REG_AW  for writeback/forwarding
//  ex_funct3    out  3       branch condition / load-store size
//  ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump  out 1  control
//  ex_illegal   out  1       registered: unknown opcode captured (slot is bubble)
// BEHAVIOUR
//  - Priority per edge: rst > flush > stall > load. rst/flush: ex_valid, all control bits,
//    ex_illegal, ex_alu_ctrl = 0; data outputs = 0. Flush during stall -> bubble.
//  - stall=1 (no flush): every output holds its value.
//  - load: in_valid=0 -> bubble. Otherwise capture decoded fields.
//  - alu_ctrl codes: ADD 0010, SUB 0110, AND 0000, OR 0001, SLL 0011, SLTU 0100, SLT 0101,
//    XOR 0111, SRL 1000, SRA 1010.
//  - R 0110011 / I 0010011: funct3 000 ADD (SUB only if R and f7_5=1), 001 SLL, 010 SLT,
//    011 SLTU, 100 XOR, 101 SRL/SRA by f7_5 (for I as well), 110 OR, 111 AND. A=rs1; B=rs2 (R) | imm (I).
//  - Shifts: op_b[XLEN-1:5] forced to 0, giving amount 0..31.
//  - LOAD 0000011 / STORE 0100011: ADD, A=rs1, B=imm. mem_read for load, mem_write for store.
//  - BRANCH 1100011: A=rs1, B=rs2, branch=1, reg_write=0.
//    funct3 00x SUB; 10x SLT; 11x SLTU.
//  - LUI 0110111: ADD, A=0, B=imm. AUIPC 0010111: ADD, A=pc, B=imm.
//  - JAL 1101111 / JALR 1100111: ADD, A=pc, B=4 (link value), jump=1, reg_write=1.
//  - reg_write=1 for R, I, LOAD, LUI, AUIPC, JAL, JALR, but forced 0 when rd=0.
//  - Any other opcode with in_valid=1: bubble with ex_illegal=1 for one slot.
//  - Arithmetic: no arithmetic in this stage; pc/imm pass unmodified; widths fixed to XLEN.
// STRUCTURE
//  - Shared package rv_pkg: ALU_* codes, OPC_* opcodes, funct3 constants.
//  - Sub-module alu_ctrl_dec (combinational): opcode/funct3/f7_5 -> alu_ctrl, selects, control, illegal.
//  - This module: selection muxes plus a single register bank with rst/flush/stall priority.
// TESTING
//  1. rst=1 for 2 cycles with in_valid=1 -> all outputs 0 on following cycle.
//  2. R SUB (f3=000, f7_5=1, rs1=7, rs2=9, rd=3) -> ex_alu_ctrl=0110, op_a=7, op_b=9,
//     reg_write=1. Same fields with opcode I -> 0010, op_b=imm.
//  3. SRAI imm=0x0000_0404 (f7_5=1) -> alu_ctrl=1010, op_b=0x4.
//     BLTU -> 0100, branch=1, reg_write=0.
//  4. JAL pc=0x100 rd=1 -> op_a=0x100, op_b=4, jump=1. Same with rd=0 -> reg_write=0.
//  5. Load ADDI, then stall 3 cycles with new inputs -> outputs unchanged.
//     stall+flush together -> bubble next cycle.
//  6. opcode 0x7F valid -> ex_valid=0, ex_illegal=1 for one cycle.
//     Next valid instr clears ex_illegal.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared ALU codes, opcodes, funct3 values and decode bundle for the ID/EX stage.
package rv_pkg;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1010;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} sel_a_t;
    typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} sel_b_t;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        sel_a_t     sel_a;
        sel_b_t     sel_b;
        logic       shamt;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       illegal;
    } dec_t;

    function automatic logic [3:0] arith_ctrl(input logic [2:0] f3, input logic sub, input logic sra);
        case (f3)
            F3_ADD:  return sub ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return sra ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: opcode/funct3/funct7[5] to ALU code, operand selects and pipeline control bits.
module alu_ctrl_dec
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output dec_t       dec
);
    always_comb begin
        dec = '0;
        dec.alu_ctrl = ALU_ADD;
        dec.sel_b = B_IMM;
        case (opcode)
            OPC_R: begin
                dec.alu_ctrl = arith_ctrl(funct3, funct7_5, funct7_5);
                dec.sel_b = B_RS2;
                dec.shamt = funct3[1:0] == 2'b01;
                dec.reg_write = 1'b1;
            end
            OPC_I: begin
                // immediate forms have no SUB; bit 30 only picks SRA vs SRL
                dec.alu_ctrl = arith_ctrl(funct3, 1'b0, funct7_5);
                dec.shamt = funct3[1:0] == 2'b01;
                dec.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                dec.reg_write = 1'b1;
                dec.mem_read = 1'b1;
            end
            OPC_STORE: dec.mem_write = 1'b1;
            OPC_BRANCH: begin
                dec.alu_ctrl = !funct3[2] ? ALU_SUB : funct3[1] ? ALU_SLTU : ALU_SLT;
                dec.sel_b = B_RS2;
                dec.branch = 1'b1;
            end
            OPC_LUI: begin
                dec.sel_a = A_ZERO;
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.sel_a = A_PC;
                dec.reg_write = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec.sel_a = A_PC;
                dec.sel_b = B_FOUR;
                dec.jump = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU control decode, operand selection, stall and flush.
module id_ex_stage
    import rv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7_5,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [REG_AW-1:0] in_rd,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic [3:0]        ex_alu_ctrl,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_pc,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] ex_rs1_addr,
    output logic [REG_AW-1:0] ex_rs2_addr,
    output logic [2:0]        ex_funct3,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic              ex_illegal
);
    dec_t dec;
    logic [XLEN-1:0] op_a, op_b_raw, op_b;
    logic load;

    alu_ctrl_dec u_dec (
        .opcode   (in_opcode),
        .funct3   (in_funct3),
        .funct7_5 (in_funct7_5),
        .dec      (dec)
    );

    always_comb begin
        op_a = dec.sel_a == A_PC ? in_pc : dec.sel_a == A_ZERO ? '0 : in_rs1_data;
        op_b_raw = dec.sel_b == B_RS2 ? in_rs2_data : dec.sel_b == B_FOUR ? XLEN'(4) : in_imm;
        op_b = dec.shamt ? {{(XLEN-5){1'b0}}, op_b_raw[4:0]} : op_b_raw;
        load = in_valid && !dec.illegal;
    end

    // a bubble zeroes everything; only ex_illegal may be set in a bubble slot
    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && !load)) begin
            ex_valid     <= 1'b0;
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_alu_ctrl  <= '0;
            ex_rs2_data  <= '0;
            ex_pc        <= '0;
            ex_rd        <= '0;
            ex_rs1_addr  <= '0;
            ex_rs2_addr  <= '0;
            ex_funct3    <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
            ex_illegal   <= !rst && !flush && in_valid && dec.illegal;
        end else if (!stall) begin
            ex_valid     <= 1'b1;
            ex_op_a      <= op_a;
            ex_op_b      <= op_b;
            ex_alu_ctrl  <= dec.alu_ctrl;
            ex_rs2_data  <= in_rs2_data;
            ex_pc        <= in_pc;
            ex_rd        <= in_rd;
            ex_rs1_addr  <= in_rs1_addr;
            ex_rs2_addr  <= in_rs2_addr;
            ex_funct3    <= in_funct3;
            ex_reg_write <= dec.reg_write && in_rd != '0;
            ex_mem_read  <= dec.mem_read;
            ex_mem_write <= dec.mem_write;
            ex_branch    <= dec.branch;
            ex_jump      <= dec.jump;
            ex_illegal   <= 1'b0;
        end
    end
endmodule
